// File: rtl/gray_seq_ctrl_pkg.sv
// gray_seq_ctrl_pkg: shared state encodings, direction codes and default width for the Gray sequencer
package gray_seq_ctrl_pkg;
  localparam int DEF_WIDTH = 3;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam logic [2:0] S_STEP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
endpackage

// File: rtl/gray_seq_ctrl_if.sv
// gray_seq_ctrl_if: command/status bundle; master issues start/stop/single_step/dir/target, slave reports busy/done/aborted/wrap/state/position
interface gray_seq_ctrl_if
  import gray_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic             stop;
  logic             single_step;
  logic             dir;
  logic [WIDTH-1:0] target;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             wrap;
  logic [2:0]       state_o;
  logic [WIDTH-1:0] pos_bin;
  logic [WIDTH-1:0] pos_gray;
  modport master (
    output start, stop, single_step, dir, target,
    input  busy, done, aborted, wrap, state_o, pos_bin, pos_gray
  );
  modport slave (
    input  start, stop, single_step, dir, target,
    output busy, done, aborted, wrap, state_o, pos_bin, pos_gray
  );
endinterface

// File: rtl/gray_seq_ctrl_count.sv
// gray_count_core: modular up/down position register with wrap pulse and Gray encode
// ports: clk, reset (async high), en_i step enable, dir_i 0=up 1=down,
//        pos_bin_o binary position, pos_gray_o Gray position, wrap_o pulse when the last step crossed max<->0
module gray_count_core
  import gray_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] pos_bin_o,
  output logic [WIDTH-1:0] pos_gray_o,
  output logic             wrap_o
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] pos_q, pos_d;
  logic             wrap_q, wrap_d;
  always_comb begin
    pos_d  = en_i ? (dir_i == DIR_DN ? pos_q - ONE : pos_q + ONE) : pos_q;
    wrap_d = en_i & (dir_i == DIR_DN ? pos_q == '0 : pos_q == '1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      wrap_q <= wrap_d;
    end
  end
  assign pos_bin_o  = pos_q;
  assign pos_gray_o = pos_q ^ (pos_q >> 1);
  assign wrap_o     = wrap_q;
endmodule

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: run/pause/step sequencer driving a Gray position counter to a latched target
// ports: clk, reset (async high), bus (slave): start/stop/single_step/dir/target commands in,
//        busy/done/aborted/wrap/state_o/pos_bin/pos_gray status out
module gray_seq_ctrl
  import gray_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  gray_seq_ctrl_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [2:0]       state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             done_q, aborted_q;
  logic             en, wrap;
  logic [WIDTH-1:0] pos, gray, nxt;
  gray_count_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .reset      (reset),
    .en_i       (en),
    .dir_i      (dir_q),
    .pos_bin_o  (pos),
    .pos_gray_o (gray),
    .wrap_o     (wrap)
  );
  // target is compared against the value the core will hold after this edge
  assign nxt = dir_q == DIR_DN ? pos - ONE : pos + ONE;
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    tgt_d   = tgt_q;
    en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dir_d   = bus.dir;
          tgt_d   = bus.target;
          state_d = bus.target == pos ? S_DONE : S_RUN;
        end else if (bus.single_step) begin
          dir_d   = bus.dir;
          state_d = S_STEP;
        end
      end
      S_RUN: begin
        en      = ~bus.stop;
        state_d = bus.stop ? S_PAUSE : nxt == tgt_q ? S_DONE : S_RUN;
      end
      S_PAUSE: state_d = bus.stop ? S_IDLE : bus.start ? S_RUN : S_PAUSE;
      S_STEP: begin
        en      = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      dir_q     <= DIR_UP;
      tgt_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      tgt_q     <= tgt_d;
      done_q    <= state_d == S_DONE;
      aborted_q <= state_q == S_PAUSE && bus.stop;
    end
  end
  assign bus.busy     = state_q != S_IDLE;
  assign bus.done     = done_q;
  assign bus.aborted  = aborted_q;
  assign bus.wrap     = wrap;
  assign bus.state_o  = state_q;
  assign bus.pos_bin  = pos;
  assign bus.pos_gray = gray;
endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: directed self-checking bench for gray_seq_ctrl
module tb_gray_seq_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  gray_seq_ctrl_if #(.WIDTH(3)) bus ();
  gray_seq_ctrl #(.WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_to(input logic [2:0] tgt, input logic d);
    bit hit = 1'b0;
    bus.start = 1'b1;
    bus.dir = d;
    bus.target = tgt;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 16 && !hit; i++) begin
      tick();
      hit = bus.done;
    end
    chk("run_to_done", int'(hit), 1);
    chk("run_to_pos", bus.pos_bin, tgt);
    tick();
  endtask
  logic [2:0] g1 [5] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7};
  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.single_step = 1'b0;
    bus.dir = 1'b0;
    bus.target = '0;
    #23 reset = 1'b0;
    #1;
    chk("rst_pos", bus.pos_bin, 0);
    chk("rst_gray", bus.pos_gray, 0);
    chk("rst_state", bus.state_o, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    // test 1: up 0 -> 5
    @(negedge clk);
    bus.start = 1'b1;
    bus.dir = 1'b0;
    bus.target = 3'd5;
    tick();
    bus.start = 1'b0;
    chk("t1_state_run", bus.state_o, 1);
    chk("t1_pos0", bus.pos_bin, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("t1_pos", bus.pos_bin, i);
      chk("t1_gray", bus.pos_gray, g1[i-1]);
      chk("t1_wrap", bus.wrap, 0);
      chk("t1_done", bus.done, i == 5 ? 1 : 0);
    end
    chk("t1_state_done", bus.state_o, 4);
    tick();
    chk("t1_busy_low", bus.busy, 0);
    chk("t1_done_low", bus.done, 0);
    // test 2: 1 -> 6 downward through wrap
    run_to(3'd1, 1'b0);
    bus.start = 1'b1;
    bus.dir = 1'b1;
    bus.target = 3'd6;
    tick();
    bus.start = 1'b0;
    tick();
    chk("t2_pos0", bus.pos_bin, 0);
    chk("t2_gray0", bus.pos_gray, 0);
    chk("t2_wrap0", bus.wrap, 0);
    tick();
    chk("t2_pos7", bus.pos_bin, 7);
    chk("t2_gray7", bus.pos_gray, 4);
    chk("t2_wrap7", bus.wrap, 1);
    chk("t2_done7", bus.done, 0);
    tick();
    chk("t2_pos6", bus.pos_bin, 6);
    chk("t2_gray6", bus.pos_gray, 5);
    chk("t2_wrap6", bus.wrap, 0);
    chk("t2_done6", bus.done, 1);
    tick();
    chk("t2_idle", bus.busy, 0);
    // test 3: pause at 3, resume ignoring new dir/target
    run_to(3'd0, 1'b0);
    bus.start = 1'b1;
    bus.dir = 1'b0;
    bus.target = 3'd7;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("t3_pos3", bus.pos_bin, 3);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("t3_pause_state", bus.state_o, 2);
    chk("t3_pause_pos", bus.pos_bin, 3);
    tick();
    chk("t3_hold_pos", bus.pos_bin, 3);
    chk("t3_hold_state", bus.state_o, 2);
    bus.start = 1'b1;
    bus.dir = 1'b1;
    bus.target = 3'd0;
    tick();
    bus.start = 1'b0;
    bus.dir = 1'b0;
    chk("t3_resume_state", bus.state_o, 1);
    for (int i = 4; i <= 7; i++) begin
      tick();
      chk("t3_resume_pos", bus.pos_bin, i);
      chk("t3_resume_done", bus.done, i == 7 ? 1 : 0);
    end
    tick();
    chk("t3_idle", bus.state_o, 0);
    // test 5a: single step up at 7 wraps to 0
    bus.single_step = 1'b1;
    bus.dir = 1'b0;
    tick();
    bus.single_step = 1'b0;
    chk("t5_step_state", bus.state_o, 3);
    chk("t5_step_hold", bus.pos_bin, 7);
    tick();
    chk("t5_step_pos", bus.pos_bin, 0);
    chk("t5_step_wrap", bus.wrap, 1);
    chk("t5_step_done", bus.done, 1);
    tick();
    chk("t5_wrap_clr", bus.wrap, 0);
    chk("t5_done_clr", bus.done, 0);
    chk("t5_idle", bus.state_o, 0);
    // test 3b: pause at 3 then abort
    bus.start = 1'b1;
    bus.target = 3'd7;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    bus.stop = 1'b1;
    tick();
    chk("t3b_pause", bus.state_o, 2);
    tick();
    bus.stop = 1'b0;
    chk("t3b_abort_state", bus.state_o, 0);
    chk("t3b_aborted", bus.aborted, 1);
    chk("t3b_abort_pos", bus.pos_bin, 3);
    chk("t3b_abort_done", bus.done, 0);
    tick();
    chk("t3b_aborted_clr", bus.aborted, 0);
    chk("t3b_no_done", bus.done, 0);
    chk("t3b_pos_kept", bus.pos_bin, 3);
    // test 4: zero-distance start
    run_to(3'd4, 1'b0);
    bus.start = 1'b1;
    bus.target = 3'd4;
    tick();
    bus.start = 1'b0;
    chk("t4_state", bus.state_o, 4);
    chk("t4_done", bus.done, 1);
    chk("t4_busy", bus.busy, 1);
    chk("t4_pos", bus.pos_bin, 4);
    tick();
    chk("t4_busy_low", bus.busy, 0);
    chk("t4_done_low", bus.done, 0);
    chk("t4_pos_held", bus.pos_bin, 4);
    // test 5b: start beats single_step
    bus.start = 1'b1;
    bus.single_step = 1'b1;
    bus.target = 3'd6;
    tick();
    bus.start = 1'b0;
    bus.single_step = 1'b0;
    chk("t5b_start_wins", bus.state_o, 1);
    tick();
    chk("t5b_pos5", bus.pos_bin, 5);
    tick();
    chk("t5b_pos6", bus.pos_bin, 6);
    chk("t5b_done", bus.done, 1);
    tick();
    // test 6: async reset mid-run at pos 2
    bus.start = 1'b1;
    bus.target = 3'd5;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_pos2", bus.pos_bin, 2);
    chk("t6_running", bus.state_o, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_pos", bus.pos_bin, 0);
    chk("t6_rst_gray", bus.pos_gray, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_state", bus.state_o, 0);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_done", bus.done, 0);
      chk("t6_stay_idle", bus.state_o, 0);
    end
    bus.start = 1'b1;
    bus.target = 3'd2;
    tick();
    bus.start = 1'b0;
    chk("t6_fresh_run", bus.state_o, 1);
    tick();
    chk("t6_fresh_pos1", bus.pos_bin, 1);
    tick();
    chk("t6_fresh_pos2", bus.pos_bin, 2);
    chk("t6_fresh_done", bus.done, 1);
    tick();
    chk("t6_fresh_idle", bus.busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
